// File: rtl/ub_pkg.sv
`default_nettype none
// ==== ub_pkg : shared size/state types and chunk helpers for ub_scratchpad (rev 1.0) ====
package ub_pkg;

  typedef enum logic [1:0] {
    UB_SZ_NONE = 2'b00,
    UB_SZ_1    = 2'b01,
    UB_SZ_2    = 2'b10,
    UB_SZ_4    = 2'b11
  } ub_size_e;

  typedef enum logic {
    UB_ST_INIT = 1'b0,
    UB_ST_RUN  = 1'b1
  } ub_state_e;

  localparam int UB_MAX_CHUNKS = 4;

  function automatic int ub_chunks(input logic [1:0] size);
    case (size)
      UB_SZ_1: return 1;
      UB_SZ_2: return 2;
      UB_SZ_4: return 4;
      default: return 0;
    endcase
  endfunction

  // Multi-chunk transfers must start on their own natural boundary.
  function automatic logic ub_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == UB_SZ_2) && addr_lo[0]) || ((size == UB_SZ_4) && (addr_lo != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ub_wr_arbiter.sv
`default_nettype none
// ==== ub_wr_arbiter : host/VPU single write-port arbiter with VPU starvation guard (rev 1.0) ====
module ub_wr_arbiter
  import ub_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic host_req,
  input  logic vpu_req,
  output logic host_gnt,
  output logic vpu_gnt
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;
  logic          at_max;

  assign at_max   = (starve_cnt == SW'(STARVE_MAX));
  assign vpu_gnt  = active && vpu_req && (!host_req || at_max);
  assign host_gnt = active && host_req && !vpu_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (vpu_gnt) begin
      starve_cnt <= '0;
    end else if (active && vpu_req && !at_max) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ub_scratchpad.sv
`default_nettype none
// ==== ub_scratchpad : unified row buffer with host, VPU-write and SA-read ports (rev 1.0) ====
module ub_scratchpad
  import ub_pkg::*;
#(
  parameter int ROWS       = 256,
  parameter int ROW_W      = 512,
  parameter int CHUNK_W    = 128,
  parameter int HOST_W     = 64,
  parameter int STARVE_MAX = 4,
  localparam int CPR       = ROW_W / CHUNK_W,
  localparam int WPR       = ROW_W / HOST_W,
  localparam int HA_W      = $clog2(ROWS * WPR),
  localparam int CA_W      = $clog2(ROWS * CPR),
  localparam int BUS_W     = UB_MAX_CHUNKS * CHUNK_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                host_en,
  input  logic                host_we,
  input  logic [HA_W-1:0]     host_addr,
  input  logic [HOST_W/8-1:0] host_wstrb,
  input  logic [HOST_W-1:0]   host_wdata,
  output logic                host_ready,
  output logic                host_rvalid,
  output logic [HOST_W-1:0]   host_rdata,
  input  logic                vpu_wr_valid,
  output logic                vpu_wr_ready,
  input  logic [CA_W-1:0]     vpu_wr_addr,
  input  logic [1:0]          vpu_wr_size,
  input  logic [BUS_W-1:0]    vpu_wr_data,
  input  logic                sa_rd_en,
  input  logic [CA_W-1:0]     sa_rd_addr,
  input  logic [1:0]          sa_rd_size,
  output logic                sa_rd_valid,
  output logic [BUS_W-1:0]    sa_rd_data,
  output logic                init_done,
  output logic                err_sticky
);

  localparam int RA_W = $clog2(ROWS);
  localparam int BI_W = $clog2(ROW_W);

  logic [ROW_W-1:0] mem [ROWS];

  ub_state_e       state, state_nxt;
  logic [RA_W-1:0] clr_row;
  logic            run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= UB_ST_INIT;
      clr_row <= '0;
    end else begin
      state <= state_nxt;
      if (state == UB_ST_INIT) begin
        clr_row <= clr_row + RA_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    init_done = 1'b0;
    case (state)
      UB_ST_INIT: begin
        if (clr_row == RA_W'(ROWS - 1)) begin
          state_nxt = UB_ST_RUN;
        end
      end
      default: begin
        init_done = 1'b1;
      end
    endcase
  end

  // A reset cycle never accepts traffic, even while the state register still shows RUN.
  assign run = (state == UB_ST_RUN) && !rst;

  logic host_rd_acc, host_wr_gnt, vpu_gnt, sa_acc;

  ub_wr_arbiter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .active  (run),
    .host_req(host_en && host_we),
    .vpu_req (vpu_wr_valid),
    .host_gnt(host_wr_gnt),
    .vpu_gnt (vpu_gnt)
  );

  assign host_rd_acc  = run && host_en && !host_we;
  assign host_ready   = host_rd_acc || host_wr_gnt;
  assign vpu_wr_ready = vpu_gnt;
  assign sa_acc       = run && sa_rd_en;

  logic [RA_W-1:0]   h_row;
  logic [BI_W-1:0]   h_base;
  logic [HOST_W-1:0] h_old, h_new;

  always_comb begin
    h_row  = RA_W'(host_addr / HA_W'(WPR));
    h_base = BI_W'(host_addr % HA_W'(WPR)) * BI_W'(HOST_W);
    h_old  = mem[h_row][h_base +: HOST_W];
    h_new  = h_old;
    for (int b = 0; b < HOST_W / 8; b++) begin
      if (host_wstrb[b]) begin
        h_new[b*8 +: 8] = host_wdata[b*8 +: 8];
      end
    end
  end

  logic [RA_W-1:0] v_row  [UB_MAX_CHUNKS];
  logic [BI_W-1:0] v_base [UB_MAX_CHUNKS];
  logic [RA_W-1:0] s_row  [UB_MAX_CHUNKS];
  logic [BI_W-1:0] s_base [UB_MAX_CHUNKS];
  int              v_n, s_n;
  logic            v_bad, s_bad, v_wr, err_set;

  // Chunk k of a transfer lives at chunk address addr+k, wrapping over the whole array.
  always_comb begin
    for (int k = 0; k < UB_MAX_CHUNKS; k++) begin
      v_row[k]  = RA_W'((vpu_wr_addr + CA_W'(k)) / CA_W'(CPR));
      v_base[k] = BI_W'((vpu_wr_addr + CA_W'(k)) % CA_W'(CPR)) * BI_W'(CHUNK_W);
      s_row[k]  = RA_W'((sa_rd_addr + CA_W'(k)) / CA_W'(CPR));
      s_base[k] = BI_W'((sa_rd_addr + CA_W'(k)) % CA_W'(CPR)) * BI_W'(CHUNK_W);
    end
  end

  always_comb begin
    v_n     = ub_chunks(vpu_wr_size);
    s_n     = ub_chunks(sa_rd_size);
    v_bad   = ub_misaligned(vpu_wr_size, vpu_wr_addr[1:0]);
    s_bad   = ub_misaligned(sa_rd_size, sa_rd_addr[1:0]);
    v_wr    = vpu_gnt && !v_bad;
    err_set = (vpu_gnt && v_bad) || (sa_acc && s_bad);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == UB_ST_INIT) begin
        mem[clr_row] <= '0;
      end else begin
        if (host_wr_gnt) begin
          mem[h_row][h_base +: HOST_W] <= h_new;
        end
        if (v_wr) begin
          for (int k = 0; k < UB_MAX_CHUNKS; k++) begin
            if (k < v_n) begin
              mem[v_row[k]][v_base[k] +: CHUNK_W] <= vpu_wr_data[k*CHUNK_W +: CHUNK_W];
            end
          end
        end
      end
    end
  end

  logic [BUS_W-1:0] sa_nxt;

  always_comb begin
    sa_nxt = '0;
    if (!s_bad) begin
      for (int k = 0; k < UB_MAX_CHUNKS; k++) begin
        if (k < s_n) begin
          sa_nxt[k*CHUNK_W +: CHUNK_W] = mem[s_row[k]][s_base[k] +: CHUNK_W];
        end
      end
    end
  end

  // Reads sample the array before this cycle's write lands, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      sa_rd_valid <= 1'b0;
      sa_rd_data  <= '0;
      err_sticky  <= 1'b0;
    end else begin
      host_rvalid <= host_rd_acc;
      host_rdata  <= host_rd_acc ? h_old : '0;
      sa_rd_valid <= sa_acc;
      sa_rd_data  <= sa_acc ? sa_nxt : '0;
      if (err_set) begin
        err_sticky <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
